// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: merges hazard, branch and
// SRAM-access stalls into per-stage register controls and counts stall cycles.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 100,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  output logic             sram_start,
  output logic             mem_busy,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t           state_r, state_nx_s;
  logic [7:0]       wait_cnt_r, wait_cnt_nx_s;
  logic             mem_timeout_r, timeout_set_s;
  logic [CNT_W-1:0] stall_cycles_r;
  logic             mem_req_s, mem_freeze_s, sram_start_s;
  logic             freeze_pc_s, freeze_if_id_s, flush_if_id_s, flush_id_exe_s, freeze_back_s;

  assign mem_req_s = mem_r_en | mem_w_en;

  // SRAM handshake next-state, watchdog count and memory-freeze request
  always_comb begin
    state_nx_s    = state_r;
    wait_cnt_nx_s = wait_cnt_r;
    sram_start_s  = 1'b0;
    mem_freeze_s  = 1'b0;
    timeout_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_req_s) begin
          sram_start_s  = 1'b1;
          mem_freeze_s  = 1'b1;
          state_nx_s    = ST_WAIT;
          wait_cnt_nx_s = 8'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (sram_ready) begin
          state_nx_s = ST_IDLE;
        end else if (wait_cnt_r < TIMEOUT_C) begin
          mem_freeze_s  = 1'b1;
          wait_cnt_nx_s = wait_cnt_r + 8'd1;
        end else begin
          mem_freeze_s  = 1'b1;
          timeout_set_s = 1'b1;
          state_nx_s    = ST_ERR;
        end
      end
      ST_ERR: begin
        mem_freeze_s = 1'b1;
        state_nx_s   = ST_ERR;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Per-stage controls: memory freeze beats branch flush beats hazard bubble
  always_comb begin
    freeze_pc_s    = 1'b0;
    freeze_if_id_s = 1'b0;
    flush_if_id_s  = 1'b0;
    flush_id_exe_s = 1'b0;
    freeze_back_s  = 1'b0;
    if (mem_freeze_s) begin
      freeze_pc_s    = 1'b1;
      freeze_if_id_s = 1'b1;
      freeze_back_s  = 1'b1;
    end else if (branch_taken) begin
      flush_if_id_s  = 1'b1;
      flush_id_exe_s = 1'b1;
    end else if (hazard_detected) begin
      freeze_pc_s    = 1'b1;
      freeze_if_id_s = 1'b1;
      flush_id_exe_s = 1'b1;
    end else begin
      freeze_pc_s = 1'b0;
    end
  end

  // FSM state, watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 8'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      wait_cnt_r    <= wait_cnt_nx_s;
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
    end
  end

  // Saturating count of PC-hold cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= {CNT_W{1'b0}};
    end else if (freeze_pc_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
      stall_cycles_r <= stall_cycles_r + CNT_W'(1'b1);
    end
  end

  assign sram_start   = sram_start_s;
  assign mem_busy     = (state_r == ST_WAIT);
  assign freeze_pc    = freeze_pc_s;
  assign freeze_if_id = freeze_if_id_s;
  assign flush_if_id  = flush_if_id_s;
  assign flush_id_exe = flush_id_exe_s;
  assign freeze_back  = freeze_back_s;
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; control vector bit order is
// {sram_start, mem_busy, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back, mem_timeout}.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic hazard_detected, branch_taken, mem_r_en, mem_w_en, sram_ready;
  logic sram_start, mem_busy, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back, mem_timeout;
  logic [31:0] stall_cycles;
  logic s_start, s_busy, s_fpc, s_fifd, s_flif, s_flie, s_fb, s_to;
  logic [3:0] s_stall;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ready(sram_ready),
    .sram_start(sram_start), .mem_busy(mem_busy), .freeze_pc(freeze_pc),
    .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .freeze_back(freeze_back), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  pipeline_stall_ctrl #(.TIMEOUT(100), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ready(sram_ready),
    .sram_start(s_start), .mem_busy(s_busy), .freeze_pc(s_fpc),
    .freeze_if_id(s_fifd), .flush_if_id(s_flif), .flush_id_exe(s_flie),
    .freeze_back(s_fb), .mem_timeout(s_to), .stall_cycles(s_stall)
  );

  wire [7:0] ctl = {sram_start, mem_busy, freeze_pc, freeze_if_id,
                    flush_if_id, flush_id_exe, freeze_back, mem_timeout};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic b, input logic r, input logic w, input logic rdy);
    hazard_detected = h;
    branch_taken    = b;
    mem_r_en        = r;
    mem_w_en        = w;
    sram_ready      = rdy;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("reset_ctl", 32'(ctl), 32'h00);
    chk("reset_stall", stall_cycles, 32'd0);
    rst = 1'b1;

    // Load with SRAM ready after 5 cycles
    tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("load_c0", 32'(ctl), 32'hB2);
    for (int i = 1; i <= 4; i++) begin
      tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("load_wait", 32'(ctl), 32'h72);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("load_ready", 32'(ctl), 32'h40);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_idle", 32'(ctl), 32'h00);
    chk("load_stall", stall_cycles, 32'd5);

    // Hazard alone for two cycles
    for (int i = 0; i < 2; i++) begin
      tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hazard", 32'(ctl), 32'h34);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hazard_end", 32'(ctl), 32'h00);
    chk("hazard_stall", stall_cycles, 32'd7);

    // Branch with simultaneous hazard: flush wins, no stall
    tick(); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_haz", 32'(ctl), 32'h0C);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_haz_stall", stall_cycles, 32'd7);

    // Branch while waiting on SRAM is held off until release
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("brw_c0", 32'(ctl), 32'hB2);
    tick(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("brw_frozen", 32'(ctl), 32'h72);
    tick(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("brw_release", 32'(ctl), 32'h4C);
    tick(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("brw_after", 32'(ctl), 32'h0C);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("brw_stall", stall_cycles, 32'd9);

    // Back-to-back stores, ready at cycles 3 and 7
    for (int c = 0; c < 8; c++) begin
      tick(); drive(1'b0, 1'b0, 1'b0, 1'b1, (c == 3 || c == 7) ? 1'b1 : 1'b0);
      if (c == 0 || c == 4) chk("b2b_start", 32'(ctl), 32'hB2);
      else if (c == 3 || c == 7) chk("b2b_ready", 32'(ctl), 32'h40);
      else chk("b2b_wait", 32'(ctl), 32'h72);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_idle", 32'(ctl), 32'h00);
    chk("b2b_stall", stall_cycles, 32'd15);

    // Watchdog: no ready, ERR after 5 WAIT cycles
    tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("to_c0", 32'(ctl), 32'hB2);
    for (int i = 1; i <= 5; i++) begin
      tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("to_wait", 32'(ctl), 32'h72);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_err", 32'(ctl), 32'h33);
    tick(); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("to_err_hold", 32'(ctl), 32'h33);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_stall", stall_cycles, 32'd23);
    rst = 1'b0;
    #1;
    chk("to_rst_ctl", 32'(ctl), 32'h00);
    chk("to_rst_stall", stall_cycles, 32'd0);
    rst = 1'b1;

    // Reset in the middle of WAIT
    tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rw_c0", 32'(ctl), 32'hB2);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rw_wait", 32'(ctl), 32'h72);
    rst = 1'b0;
    #1;
    chk("rw_rst", 32'(ctl), 32'h00);
    tick();
    rst = 1'b1;
    tick();
    chk("rw_idle", 32'(ctl), 32'h00);
    chk("rw_stall", stall_cycles, 32'd0);

    // Saturation on the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_main", stall_cycles, 32'd20);
    chk("sat_4b", 32'(s_stall), 32'd15);
    tick();
    chk("sat_hold", 32'(s_stall), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Combines three sources into per-stage pipeline-register controls:
  - combinational hazard_detected from the hazard unit
  - branch_taken from EXE
  - multi-cycle SRAM access requests from MEM
- Owns the SRAM handshake FSM with a watchdog timeout, and a stall-cycle performance counter.

Parameters:
- TIMEOUT, 100: max cycles in WAIT without sram_ready before error (1..255).
- CNT_W, 32: width of stall_cycles performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- hazard_detected  input  1  RAW hazard from hazard unit.
- branch_taken  input  1  EXE-stage branch resolved taken.
- mem_r_en  input  1  MEM-stage load request.
- mem_w_en  input  1  MEM-stage store request.
- sram_ready  input  1  SRAM access complete, valid for one cycle.
- sram_start  output  1  one-cycle pulse launching SRAM access.
- mem_busy  output  1  FSM in WAIT.
- freeze_pc  output  1  hold PC.
- freeze_if_id  output  1  hold IF/ID register.
- flush_if_id  output  1  clear IF/ID register to NOP.
- flush_id_exe  output  1  load bubble into ID/EXE register.
- freeze_back  output  1  hold ID/EXE, EXE/MEM, MEM/WB registers.
- mem_timeout  output  1  sticky SRAM watchdog error.
- stall_cycles  output  CNT_W  saturating count of cycles with freeze_pc=1.

Behaviour:
- State: FSM {IDLE, WAIT, ERR}, 8-bit wait_cnt, stall_cycles. All reset asynchronously on rst=0 to IDLE / 0 / 0.
- Reset value of outputs: sram_start=0, mem_busy=0, mem_timeout=0, stall_cycles=0. The remaining outputs are combinational from state and inputs; with state=IDLE and all inputs 0 they are all 0.
- mem_req = mem_r_en | mem_w_en.

FSM transitions:
- IDLE, mem_req=1: sram_start=1 (combinational, same cycle); next WAIT; wait_cnt<=0.
- IDLE, mem_req=0: stay. sram_ready is ignored in IDLE.
- WAIT, sram_ready=1: next IDLE. Freeze is released in this same cycle so the pipeline advances at this edge. The next cycle's mem_req belongs to a new instruction and may start immediately.
- WAIT, sram_ready=0, wait_cnt<TIMEOUT: wait_cnt<=wait_cnt+1.
- WAIT, sram_ready=0, wait_cnt==TIMEOUT: next ERR; mem_timeout<=1.
- ERR: absorbing until rst. Full freeze held, sram_start=0.

mem_freeze = (IDLE & mem_req) | (WAIT & ~sram_ready) | ERR.

Output priority (highest first):
1. mem_freeze=1:
   - freeze_pc=freeze_if_id=freeze_back=1; flush_if_id=flush_id_exe=0.
   - branch_taken and hazard_detected are ignored; both are re-evaluated once the freeze releases, because their source registers are held.
2. branch_taken=1:
   - flush_if_id=1, flush_id_exe=1; all freezes 0.
   - A simultaneous hazard is discarded because the offending instruction is flushed.
3. hazard_detected=1:
   - freeze_pc=1, freeze_if_id=1, flush_id_exe=1; freeze_back=0; flush_if_id=0.
4. Otherwise: all controls 0.

Other rules:
- mem_busy = (state==WAIT).
- stall_cycles increments on every clock edge where freeze_pc=1; holds at all-ones (no wrap).
- Reset mid-WAIT: FSM returns to IDLE immediately (async). No sram_start is issued until rst deasserts and mem_req is seen in IDLE.
- Latency: zero-cycle combinational path from all inputs to the control outputs. Registered state only.

Test Plan:
- Load, SRAM ready after 5 cycles: mem_r_en=1 at cycle 0, sram_ready at cycle 5 -> sram_start=1 only at cycle 0; freeze_back=1 at cycles 0-4, 0 at cycle 5; mem_busy=1 at cycles 1-5; stall_cycles=5.
- Hazard alone for 2 cycles: freeze_pc=freeze_if_id=flush_id_exe=1 for exactly those 2 cycles; freeze_back=0; stall_cycles +2.
- branch_taken=1 with hazard_detected=1 in the same cycle -> flush_if_id=flush_id_exe=1, freeze_pc=0, stall_cycles unchanged.
- branch_taken=1 during WAIT -> no flush while frozen; after the sram_ready cycle, a still-asserted branch_taken produces flush_if_id=1.
- TIMEOUT=4, sram_ready never asserted -> ERR entered after 5 WAIT cycles; mem_timeout=1 sticky; full freeze held; rst=0 clears all state; sram_start=0 throughout ERR.
- Back-to-back stores: mem_w_en held high, sram_ready at cycles 3 and 7 -> second sram_start at cycle 4; stall_cycles=6.
- Saturation: with CNT_W=4 and continuous hazard for 20 cycles -> stall_cycles=15 and holds.
